eq_serial_ctrl: RTL and testbench
=================================

EQ_SERIAL_CTRL -- requirements
Module: eq_serial_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..64.
REQ-002 Parameter IDXW, default $clog2(WIDTH), width of the bit-index outputs.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start_valid  input  1  request holds a valid operand pair.
REQ-006 start_ready  output  1  controller can accept a request.
REQ-007 a  input  WIDTH  operand A, sampled on start handshake.
REQ-008 b  input  WIDTH  operand B, sampled on start handshake.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer accepts result.
REQ-011 res_eq  output  1  1 = A equals B across all WIDTH bits.
REQ-012 res_idx  output  IDXW  index of the first mismatching bit, LSB-first; 0 when res_eq=1.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The start handshake SHALL complete on a clock edge with start_valid=1 and start_ready=1; a and b SHALL be captured into internal shift registers on that edge.
REQ-015 FSM states SHALL be IDLE, CMP, DONE; IDLE->CMP on the start handshake; CMP->DONE on the first mismatch or after bit WIDTH-1 is compared; DONE->IDLE on the result handshake.
REQ-016 start_ready SHALL be 1 only in IDLE; res_valid SHALL be 1 only in DONE.
REQ-017 In CMP the controller SHALL present exactly one bit pair per cycle, at index cnt, to a single 1-bit equality comparator; cnt starts at 0 and increments by 1 per CMP cycle.
REQ-018 On a mismatch at index k, the FSM SHALL enter DONE on the next edge with res_eq=0, res_idx=k; bits above k SHALL NOT be compared.
REQ-019 If all bits match, DONE SHALL be entered after exactly WIDTH CMP cycles with res_eq=1, res_idx=0.
REQ-020 Latency from start handshake edge to res_valid=1 SHALL be k+1 cycles for a first mismatch at k, and WIDTH cycles for an equal pair.
REQ-021 res_eq and res_idx SHALL be registered and stable while res_valid=1 and res_ready=0 (backpressure of any length).
REQ-022 The result handshake SHALL complete on an edge with res_valid=1 and res_ready=1; start_ready SHALL rise on the following cycle (no same-cycle restart).
REQ-023 Changes to a, b, or start_valid outside IDLE SHALL NOT affect the operation in progress.
REQ-024 cnt SHALL NOT wrap; it saturates at WIDTH-1, and the CMP exit decision uses cnt==WIDTH-1.

Reset
REQ-025 With reset=1 at a clock edge: state=IDLE, cnt=0, res_eq=0, res_idx=0, res_valid=0, busy=0, start_ready=1 after the edge.
REQ-026 Reset asserted in CMP or DONE SHALL abort the operation and discard any pending result; no res_valid pulse SHALL follow.
REQ-027 reset SHALL take priority over simultaneous start or result handshakes.

Structure
REQ-028 A shared package eq_ctrl_pkg SHALL hold the FSM state enum (IDLE, CMP, DONE) and the default WIDTH constant.
REQ-029 The bit compare SHALL be one instance of the existing 1-bit comparator eq1; no other sub-modules.

Verification
REQ-030 WIDTH=8, a=8'hA5, b=8'hA5, res_ready=1 -> res_valid 8 cycles after start, res_eq=1, res_idx=0.
REQ-031 a=8'hA5, b=8'hA4 -> res_valid 1 cycle after start, res_eq=0, res_idx=0.
REQ-032 a=8'h05, b=8'h85 -> res_valid 8 cycles after start, res_eq=0, res_idx=7.
REQ-033 Mismatch at bit 3, res_ready held 0 for 10 cycles -> res_valid, res_eq=0, res_idx=3 stable throughout; start_ready=0 throughout; start_ready=1 the cycle after res_ready rises.
REQ-034 reset pulsed at CMP cycle 4 of an equal-pair compare -> IDLE, start_ready=1 next cycle, no res_valid; new request a=b=8'h00 completes with res_eq=1.
REQ-035 start_valid held 1 with a, b toggling every cycle during CMP -> result matches the pair captured at the handshake.

Source files
------------

// File: rtl/eq_ctrl_pkg.sv
// Shared types and constants for the serial equality controller.
package eq_ctrl_pkg;

    localparam int EQ_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } eq_state_t;

endpackage

// File: rtl/eq1.sv
// Single-bit equality comparator.
module eq1 (
    input  logic x,
    input  logic y,
    output logic eq
);

    assign eq = ~(x ^ y);

endmodule

// File: rtl/eq_serial_ctrl.sv
// Bit-serial A==B comparator: one bit pair per cycle, LSB first, stops at the first mismatch.
//
// state | meaning
// IDLE  | waiting for a start handshake, start_ready=1
// CMP   | comparing bit cnt of the captured operands
// DONE  | result held on res_eq/res_idx until res_ready
module eq_serial_ctrl
    import eq_ctrl_pkg::*;
#(
    parameter int WIDTH = EQ_DEFAULT_WIDTH,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_eq,
    output logic [IDXW-1:0]  res_idx,
    output logic             busy
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    eq_state_t        state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [IDXW-1:0]  cnt;
    logic             bit_eq;

    // Operands shift right each CMP cycle, so bit 0 always holds index cnt.
    eq1 u_eq1 (
        .x  (sa[0]),
        .y  (sb[0]),
        .eq (bit_eq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sa          <= '0;
            sb          <= '0;
            res_eq      <= 1'b0;
            res_idx     <= '0;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        sa          <= a;
                        sb          <= b;
                        cnt         <= '0;
                        state       <= CMP;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                CMP: begin
                    if (!bit_eq) begin
                        res_eq    <= 1'b0;
                        res_idx   <= cnt;
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end else if (cnt == LAST_IDX) begin
                        res_eq    <= 1'b1;
                        res_idx   <= '0;
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        sa  <= sa >> 1;
                        sb  <= sb >> 1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        cnt         <= '0;
                        state       <= IDLE;
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    res_valid   <= 1'b0;
                    start_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_serial_ctrl.sv
// Self-checking bench for eq_serial_ctrl with WIDTH=8.
module tb_eq_serial_ctrl;

    localparam int W  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic          res_eq;
    logic [IW-1:0] res_idx;
    logic          busy;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    eq_serial_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_eq      (res_eq),
        .res_idx     (res_idx),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 comparing (countdown to result), 2 result held.
    int          m_phase = 0;
    int          m_rem   = 0;
    logic        m_eq    = 1'b0;
    int          m_idx   = 0;
    logic        p_eq;
    int          p_idx;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_eq    = 1'b0;
            m_idx   = 0;
        end else begin
            case (m_phase)
                0: if (start_valid) begin
                    p_eq  = 1'b1;
                    p_idx = 0;
                    m_rem = W;
                    for (int i = W - 1; i >= 0; i--) begin
                        if (a[i] != b[i]) begin
                            p_eq  = 1'b0;
                            p_idx = i;
                            m_rem = i + 1;
                        end
                    end
                    m_phase = 1;
                end
                1: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_phase = 2;
                        m_eq    = p_eq;
                        m_idx   = p_idx;
                    end
                end
                default: if (res_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model start_ready", 64'(start_ready), 64'(m_phase == 0));
            chk("model res_valid",   64'(res_valid),   64'(m_phase == 2));
            chk("model busy",        64'(busy),        64'(m_phase != 0));
            chk("model res_eq",      64'(res_eq),      64'(m_eq));
            chk("model res_idx",     64'(res_idx),     64'(m_idx));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake one pair, wait for the result with res_ready=1, check literals.
    task automatic run(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input bit toggle, input logic exp_eq,
                       input int exp_idx, input int exp_lat);
        int lat;
        res_ready   = 1'b1;
        a           = va;
        b           = vb;
        start_valid = 1'b1;
        tick();
        start_valid = toggle;
        lat = 0;
        while (lat < 40) begin
            if (toggle) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            tick();
            lat++;
            if (res_valid) break;
        end
        start_valid = 1'b0;
        chk("latency",  64'(lat),     64'(exp_lat));
        chk("res_eq",   64'(res_eq),  64'(exp_eq));
        chk("res_idx",  64'(res_idx), 64'(exp_idx));
        tick();
        chk("start_ready after result", 64'(start_ready), 64'd1);
    endtask

    initial begin
        int waited;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset start_ready", 64'(start_ready), 64'd1);
        chk("reset busy",        64'(busy),        64'd0);
        chk("reset res_valid",   64'(res_valid),   64'd0);
        chk("reset res_eq",      64'(res_eq),      64'd0);
        chk("reset res_idx",     64'(res_idx),     64'd0);

        run(8'hA5, 8'hA5, 1'b0, 1'b1, 0, 8);
        run(8'hA5, 8'hA4, 1'b0, 1'b0, 0, 1);
        run(8'h05, 8'h85, 1'b0, 1'b0, 7, 8);
        run(8'hF0, 8'hE0, 1'b0, 1'b0, 4, 5);

        // Backpressure on a bit-3 mismatch.
        res_ready   = 1'b0;
        a           = 8'h00;
        b           = 8'h08;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        waited = 0;
        while (!res_valid && waited < 40) begin
            tick();
            waited++;
        end
        chk("bp latency", 64'(waited), 64'd4);
        for (int i = 0; i < 10; i++) begin
            chk("bp res_valid",   64'(res_valid),   64'd1);
            chk("bp res_eq",      64'(res_eq),      64'd0);
            chk("bp res_idx",     64'(res_idx),     64'd3);
            chk("bp start_ready", 64'(start_ready), 64'd0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        chk("bp release start_ready", 64'(start_ready), 64'd1);
        chk("bp release res_valid",   64'(res_valid),   64'd0);

        // Reset in CMP cycle 4 of an equal-pair compare.
        a           = 8'hFF;
        b           = 8'hFF;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort start_ready", 64'(start_ready), 64'd1);
        chk("abort busy",        64'(busy),        64'd0);
        for (int i = 0; i < 10; i++) begin
            chk("abort no res_valid", 64'(res_valid), 64'd0);
            tick();
        end
        run(8'h00, 8'h00, 1'b0, 1'b1, 0, 8);

        // Reset wins over a simultaneous start handshake.
        a           = 8'h01;
        b           = 8'h00;
        start_valid = 1'b1;
        reset       = 1'b1;
        tick();
        reset       = 1'b0;
        start_valid = 1'b0;
        chk("reset priority busy", 64'(busy), 64'd0);
        tick();

        // Inputs churning during CMP must not disturb the captured pair.
        run(8'h3C, 8'h3C, 1'b1, 1'b1, 0, 8);
        run(8'h10, 8'h00, 1'b1, 1'b0, 4, 5);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
